// File: rtl/rf_wport_arbiter_if.sv
// Signal bundle around the register-file write-port arbiter.
// The arbiter uses the slave view. The surrounding pipeline (or a bench) uses the master view.
interface rf_wport_arbiter_if #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wb_we;
  logic [AW-1:0]     wb_wn;
  logic [DW-1:0]     wb_d;
  logic              lw_valid;
  logic [AW-1:0]     lw_wn;
  logic [DW-1:0]     lw_d;
  logic              lw_ready;
  logic              issue_valid;
  logic [AW-1:0]     issue_wn;
  logic [AW-1:0]     rna;
  logic [AW-1:0]     rnb;
  logic [AW-1:0]     dec_wn;
  logic              stall;
  logic              rf_we;
  logic [AW-1:0]     rf_wn;
  logic [DW-1:0]     rf_d;
  logic [2**AW-1:0]  pend;
  logic [CW-1:0]     fifo_cnt;

  modport master (
    output wb_we, wb_wn, wb_d, lw_valid, lw_wn, lw_d,
           issue_valid, issue_wn, rna, rnb, dec_wn,
    input  lw_ready, stall, rf_we, rf_wn, rf_d, pend, fifo_cnt
  );

  modport slave (
    input  wb_we, wb_wn, wb_d, lw_valid, lw_wn, lw_d,
           issue_valid, issue_wn, rna, rnb, dec_wn,
    output lw_ready, stall, rf_we, rf_wn, rf_d, pend, fifo_cnt
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the single register-file write port between writeback (fixed priority) and a FIFO
// of long-latency results. It also keeps the pending-destination scoreboard that drives the decode stall.
module rf_wport_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              clrn,
  rf_wport_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2**AW;

  logic [AW-1:0] wn_mem [DEPTH];
  logic [DW-1:0] d_mem  [DEPTH];

  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [NR-1:0] pend_reg;
  logic [NR-1:0] pend_next;

  logic          wb_act;
  logic          fifo_ne;
  logic          ready;
  logic          push;
  logic          pop;
  logic [AW-1:0] head_wn;
  logic [DW-1:0] head_d;

  logic          sel_we;
  logic [AW-1:0] sel_wn;
  logic [DW-1:0] sel_d;

  assign wb_act  = bus.wb_we && (bus.wb_wn != '0);
  assign fifo_ne = (cnt_reg != '0);
  // Readiness comes from the registered count only. A full FIFO stays not-ready even while it drains.
  assign ready   = (cnt_reg < CW'(DEPTH)) && clrn;
  assign push    = bus.lw_valid && ready;
  assign pop     = fifo_ne && !wb_act;
  assign head_wn = wn_mem[rd_ptr_reg];
  assign head_d  = d_mem[rd_ptr_reg];

  always_comb begin
    sel_we = 1'b0;
    sel_wn = '0;
    sel_d  = '0;
    if (wb_act) begin
      sel_we = 1'b1;
      sel_wn = bus.wb_wn;
      sel_d  = bus.wb_d;
    end else if (fifo_ne) begin
      // A queued result for r0 still pops, but it must not reach the register file.
      sel_we = (head_wn != '0);
      sel_wn = head_wn;
      sel_d  = head_d;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + CW'(1);
      2'b01:   cnt_next = cnt_reg - CW'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  // Per-register scoreboard update. An issue in the same cycle overrides the clear from a drain.
  assign pend_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NR; gi++) begin : g_pend
      assign pend_next[gi] = (bus.issue_valid && (bus.issue_wn == AW'(gi))) ||
                             (pend_reg[gi] && !(pop && (head_wn == AW'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
      pend_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      cnt_reg  <= cnt_next;
      pend_reg <= pend_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wn_mem[wr_ptr_reg] <= bus.lw_wn;
      d_mem[wr_ptr_reg]  <= bus.lw_d;
    end
  end

  assign bus.lw_ready = ready;
  // The register file samples on the following negedge, so a reset edge must kill the enable at once.
  assign bus.rf_we    = sel_we && clrn;
  assign bus.rf_wn    = sel_wn;
  assign bus.rf_d     = sel_d;
  assign bus.pend     = pend_reg;
  assign bus.fifo_cnt = cnt_reg;
  assign bus.stall    = ((bus.rna    != '0) && pend_reg[bus.rna]) ||
                        ((bus.rnb    != '0) && pend_reg[bus.rnb]) ||
                        ((bus.dec_wn != '0) && pend_reg[bus.dec_wn]);
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized and directed bench for rf_wport_arbiter.
// The DUT is checked every cycle against a queue-based reference model of the write port and scoreboard.
module tb_rf_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [AW-1:0] wn;
    logic [DW-1:0] d;
  } ent_t;

  logic clk;
  logic clrn;
  rf_wport_arbiter_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

  rf_wport_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t       mq[$];
  logic [31:0] mpend;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus.wb_we = 0; bus.wb_wn = 0; bus.wb_d = 0;
    bus.lw_valid = 0; bus.lw_wn = 0; bus.lw_d = 0;
    bus.issue_valid = 0; bus.issue_wn = 0;
    bus.rna = 0; bus.rnb = 0; bus.dec_wn = 0;
  endtask

  // Check all outputs against the model, then advance one clock and update the model from the sampled inputs.
  task automatic step();
    logic          wa;
    logic          e_we;
    logic [AW-1:0] e_wn;
    logic [DW-1:0] e_d;
    logic          e_stall;
    logic          rdy;
    ent_t          e;
    #1;
    wa = bus.wb_we && (bus.wb_wn != 0);
    e_we = 0; e_wn = 0; e_d = 0;
    if (wa) begin
      e_we = 1; e_wn = bus.wb_wn; e_d = bus.wb_d;
    end else if (mq.size() > 0) begin
      e_we = (mq[0].wn != 0); e_wn = mq[0].wn; e_d = mq[0].d;
    end
    e_stall = ((bus.rna != 0) && mpend[bus.rna]) || ((bus.rnb != 0) && mpend[bus.rnb]) ||
              ((bus.dec_wn != 0) && mpend[bus.dec_wn]);
    check("rf_we", 64'(bus.rf_we), 64'(e_we));
    check("rf_wn", 64'(bus.rf_wn), 64'(e_wn));
    check("rf_d", 64'(bus.rf_d), 64'(e_d));
    check("lw_ready", 64'(bus.lw_ready), 64'(mq.size() < DEPTH));
    check("fifo_cnt", 64'(bus.fifo_cnt), 64'(mq.size()));
    check("pend", 64'(bus.pend), 64'(mpend));
    check("stall", 64'(bus.stall), 64'(e_stall));
    if (e_we) $display("t=%0t write r%0d = %h (%s)", $time, e_wn, e_d, wa ? "wb" : "fifo");
    @(posedge clk);
    rdy = (mq.size() < DEPTH);
    if (!wa && mq.size() > 0) begin
      e = mq.pop_front();
      if (e.wn != 0) mpend[e.wn] = 1'b0;
    end
    if (bus.lw_valid && rdy) begin
      e.wn = bus.lw_wn; e.d = bus.lw_d;
      mq.push_back(e);
    end
    if (bus.issue_valid && bus.issue_wn != 0) mpend[bus.issue_wn] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    clrn = 0;
    mpend = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_lw_ready", 64'(bus.lw_ready), 64'd0);
    check("rst_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("rst_pend", 64'(bus.pend), 64'd0);
    check("rst_rf_we", 64'(bus.rf_we), 64'd0);
    @(negedge clk);
    clrn = 1;
    step();
    check("idle_ready", 64'(bus.lw_ready), 64'd1);

    // Issue r5, then its result returns three cycles later while WB is idle.
    bus.issue_valid = 1; bus.issue_wn = 5; step();
    bus.issue_valid = 0; bus.rna = 5;
    repeat (2) step();
    bus.lw_valid = 1; bus.lw_wn = 5; bus.lw_d = 32'h1234; step();
    bus.lw_valid = 0;
    #1;
    check("r5_drain_we", 64'(bus.rf_we), 64'd1);
    check("r5_drain_d", 64'(bus.rf_d), 64'h1234);
    check("r5_stall_before", 64'(bus.stall), 64'd1);
    step();
    check("r5_pend_clear", 64'(bus.pend[5]), 64'd0);
    bus.rna = 0;
    step();

    // WB writes r3 every cycle while two results queue up.
    bus.wb_we = 1; bus.wb_wn = 3; bus.wb_d = 32'h33;
    bus.lw_valid = 1; bus.lw_wn = 7; bus.lw_d = 32'hA; step();
    bus.lw_wn = 8; bus.lw_d = 32'hB; step();
    bus.lw_valid = 0; step();
    check("full_cnt", 64'(bus.fifo_cnt), 64'd2);
    check("full_ready", 64'(bus.lw_ready), 64'd0);
    bus.wb_we = 0;
    repeat (3) step();

    // Pending r9 stalls via dec_wn; a WB write to r0 lets the FIFO drain.
    bus.issue_valid = 1; bus.issue_wn = 9; step();
    bus.issue_valid = 0; bus.dec_wn = 9;
    #1;
    check("stall_dec_wn", 64'(bus.stall), 64'd1);
    bus.wb_we = 1; bus.wb_wn = 3; bus.lw_valid = 1; bus.lw_wn = 9; bus.lw_d = 32'h99; step();
    bus.lw_valid = 0; bus.wb_wn = 0;
    #1;
    check("wb_r0_drain_wn", 64'(bus.rf_wn), 64'd9);
    step();
    bus.wb_we = 0; bus.dec_wn = 0; step();

    // A drain of r4 and a new issue to r4 land in the same cycle.
    bus.issue_valid = 1; bus.issue_wn = 4; step();
    bus.issue_valid = 0;
    bus.wb_we = 1; bus.wb_wn = 3; bus.lw_valid = 1; bus.lw_wn = 4; bus.lw_d = 32'h44; step();
    bus.lw_valid = 0; bus.wb_we = 0; bus.issue_valid = 1; bus.issue_wn = 4; step();
    bus.issue_valid = 0;
    check("pend4_set_wins", 64'(bus.pend[4]), 64'd1);
    step();

    // Fill the FIFO with pending results, then reset in the middle of a cycle.
    bus.issue_valid = 1; bus.issue_wn = 10; step();
    bus.issue_wn = 11; step();
    bus.issue_valid = 0; bus.wb_we = 1; bus.wb_wn = 3;
    bus.lw_valid = 1; bus.lw_wn = 10; bus.lw_d = 32'h10; step();
    bus.lw_wn = 11; bus.lw_d = 32'h11; step();
    idle_inputs();
    #2;
    clrn = 0;
    #1;
    check("mid_rst_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("mid_rst_pend", 64'(bus.pend), 64'd0);
    check("mid_rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("mid_rst_ready", 64'(bus.lw_ready), 64'd0);
    mq.delete();
    mpend = 0;
    @(negedge clk);
    clrn = 1;
    step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.wb_we       = ($urandom_range(0, 9) < 5);
      bus.wb_wn       = AW'($urandom_range(0, 31));
      bus.wb_d        = $urandom;
      bus.lw_valid    = ($urandom_range(0, 9) < 5);
      bus.lw_wn       = AW'($urandom_range(0, 31));
      bus.lw_d        = $urandom;
      bus.issue_valid = ($urandom_range(0, 9) < 3);
      bus.issue_wn    = AW'($urandom_range(0, 31));
      bus.rna         = AW'($urandom_range(0, 31));
      bus.rnb         = AW'($urandom_range(0, 31));
      bus.dec_wn      = AW'($urandom_range(0, 31));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
